// File: rtl/io_bus_master_if.sv
// ---------------------------------------------------------------------------
// io_bus_master_if
// Bundles the request/response handshake and the IO bus of io_bus_master.
//   req_*   : request channel (valid/ready, 2-bit op, 32-bit write data)
//   rsp_*   : response channel (valid/ready, 32-bit read data, error flag)
//   io_*    : IO bus (8-bit address, 32-bit write data, write/read strobes,
//             32-bit read data that the responder returns combinationally)
// Modports: master (the io_bus_master side), slave (requester + responder).
// ---------------------------------------------------------------------------
interface io_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;

    modport master (
        input  req_valid, req_op, req_wdata, rsp_ready, io_din,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               io_addr, io_dout, io_we, io_rd
    );

    modport slave (
        output req_valid, req_op, req_wdata, rsp_ready, io_din,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               io_addr, io_dout, io_we, io_rd
    );
endinterface

// File: rtl/io_bus_master.sv
// ---------------------------------------------------------------------------
// io_bus_master
// Turns single requests into IO bus transactions. LED write (op 00) and
// CNT read (op 11) go straight to a one-cycle transfer; SEG write (op 01)
// and SWX read (op 10) first poll a status register until bit 0 is set,
// with POLL_GAP idle cycles between polls.
// Ports:
//   clk   : clock, rising edge
//   rstn  : asynchronous active-low reset
//   bus   : io_bus_master_if.master (request, response and IO bus signals)
//   busy  : high whenever the FSM is not in IDLE
// Parameters:
//   POLL_GAP : idle cycles between status polls (0..255)
//   TIMEOUT  : status polls allowed per request before abort (1..65535)
// Optional feature: define IOM_TIMEOUT_EN to abort a request with rsp_err=1
// after TIMEOUT unsuccessful polls; without it polling never gives up.
// ---------------------------------------------------------------------------
module io_bus_master #(
    parameter int POLL_GAP = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic            clk,
    input  logic            rstn,
    io_bus_master_if.master bus,
    output logic            busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_GAP,
        ST_XFER,
        ST_RESP
    } state_t;

    localparam logic [1:0] OP_LED = 2'b00;
    localparam logic [1:0] OP_SEG = 2'b01;
    localparam logic [1:0] OP_SWX = 2'b10;

    // Last GAP count value before the next poll (unused when POLL_GAP is 0).
    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [7:0]  status_addr;

`ifdef IOM_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        rsp_err_q, rsp_err_d;
`else
    // TIMEOUT only matters with the abort feature; this keeps the range
    // visible in elaboration without generating any logic.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_out_of_range
    end
`endif

    assign status_addr = (op_q == OP_SEG) ? 8'h08 : 8'h10;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            op_q       <= 2'b00;
            wdata_q    <= 32'h0;
            gap_cnt_q  <= 8'h0;
            rsp_data_q <= 32'h0;
`ifdef IOM_TIMEOUT_EN
            poll_cnt_q <= 16'h0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wdata_q    <= wdata_d;
            gap_cnt_q  <= gap_cnt_d;
            rsp_data_q <= rsp_data_d;
`ifdef IOM_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wdata_d    = wdata_q;
        gap_cnt_d  = gap_cnt_q;
        rsp_data_d = rsp_data_q;
        io_addr    = 8'h00;
        io_dout    = 32'h0;
        io_we      = 1'b0;
        io_rd      = 1'b0;
`ifdef IOM_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
        rsp_err_d  = rsp_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d       = bus.req_op;
                    wdata_d    = bus.req_wdata;
                    rsp_data_d = 32'h0;
                    gap_cnt_d  = 8'h0;
`ifdef IOM_TIMEOUT_EN
                    poll_cnt_d = 16'h0;
                    rsp_err_d  = 1'b0;
`endif
                    // SEG write and SWX read must wait for their status bit.
                    if (bus.req_op == OP_SEG || bus.req_op == OP_SWX) begin
                        state_d = ST_POLL;
                    end else begin
                        state_d = ST_XFER;
                    end
                end
            end
            ST_POLL: begin
                io_addr = status_addr;
                io_rd   = 1'b1;
                if (bus.io_din[0]) begin
                    state_d = ST_XFER;
                end else begin
`ifdef IOM_TIMEOUT_EN
                    poll_cnt_d = poll_cnt_q + 16'h1;
                    if (poll_cnt_q == TIMEOUT_LAST) begin
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end else
`endif
                    if (POLL_GAP == 0) begin
                        state_d = ST_POLL;
                    end else begin
                        gap_cnt_d = 8'h0;
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                // Address stays on the status register so the bus is quiet.
                io_addr = status_addr;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = 8'h0;
                    state_d   = ST_POLL;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'h1;
                end
            end
            ST_XFER: begin
                unique case (op_q)
                    OP_LED: begin
                        io_addr = 8'h00;
                        io_we   = 1'b1;
                        io_dout = wdata_q;
                    end
                    OP_SEG: begin
                        io_addr = 8'h0C;
                        io_we   = 1'b1;
                        io_dout = wdata_q;
                    end
                    OP_SWX: begin
                        io_addr    = 8'h14;
                        io_rd      = 1'b1;
                        rsp_data_d = bus.io_din;
                    end
                    default: begin
                        io_addr    = 8'h18;
                        io_rd      = 1'b1;
                        rsp_data_d = bus.io_din;
                    end
                endcase
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_data  = rsp_data_q;
`ifdef IOM_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
    assign bus.io_addr   = io_addr;
    assign bus.io_dout   = io_dout;
    assign bus.io_we     = io_we;
    assign bus.io_rd     = io_rd;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_io_bus_master.sv
module tb_io_bus_master;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic busy;

    io_bus_master_if bus();

    io_bus_master #(.POLL_GAP(4), .TIMEOUT(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Responder model
    int          seg_polls = 0;
    int          seg_base  = 0;
    int          seg_zero  = 0;
    logic        swx_status = 1'b0;
    logic [31:0] cnt_val = 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.io_rd && bus.io_addr == 8'h08) seg_polls <= seg_polls + 1;
    end

    always_comb begin
        bus.io_din = 32'h0;
        case (bus.io_addr)
            8'h08:   bus.io_din = {31'h0, ((seg_polls - seg_base) >= seg_zero)};
            8'h10:   bus.io_din = {31'h0, swx_status};
            8'h14:   bus.io_din = 32'hDEADBEEF;
            8'h18:   bus.io_din = cnt_val;
            default: bus.io_din = 32'h0;
        endcase
    end

    // Bus monitor
    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic        we;
        logic        rd;
        logic [31:0] dout;
    } ev_t;
    ev_t log_q[$];
    int  rsp_seen = 0;
    int  both_cnt = 0;

    always @(negedge clk) begin
        if (rstn && (bus.io_we || bus.io_rd)) begin
            log_q.push_back('{cyc: cyc, addr: bus.io_addr, we: bus.io_we, rd: bus.io_rd, dout: bus.io_dout});
        end
        if (bus.io_we && bus.io_rd) both_cnt++;
        if (bus.rsp_valid) rsp_seen++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] wd, output int acc);
        @(negedge clk);
        check_val("req_ready_before_issue", {31'h0, bus.req_ready}, 32'h1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_wdata = wd;
        acc = cyc;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        $display("issue op=%0d wdata=0x%08h at cycle %0d", op, wd, acc);
    endtask

    task automatic wait_rsp(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check_val("rsp_wait_expired", 32'h0, 32'h1);
    endtask

    task automatic accept_rsp();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check_val("rsp_valid_after_accept", {31'h0, bus.rsp_valid}, 32'h0);
        check_val("req_ready_after_accept", {31'h0, bus.req_ready}, 32'h1);
    endtask

    initial begin
        int acc;
        int at;
        int polls;
        int wes;
        int seen0;

        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        check_val("rst_busy",      {31'h0, busy}, 32'h0);
        check_val("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        check_val("rst_io_addr",   {24'h0, bus.io_addr}, 32'h0);
        check_val("rst_io_strobe", {30'h0, bus.io_we, bus.io_rd}, 32'h0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset released at cycle %0d", cyc);

        // LED write: no polling, response two cycles after accept
        log_q.delete();
        issue(2'b00, 32'h0000A5A5, acc);
        wait_rsp(20, at);
        check_val("led_latency", at - acc, 2);
        check_val("led_events", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            check_val("led_addr", {24'h0, log_q[0].addr}, 32'h00);
            check_val("led_we",   {31'h0, log_q[0].we}, 32'h1);
            check_val("led_dout", log_q[0].dout, 32'h0000A5A5);
        end
        check_val("led_rsp_data", bus.rsp_data, 32'h0);
        accept_rsp();
        $display("LED write rsp at cycle %0d data=0x%08h", at, bus.rsp_data);

        // SEG write: status reads 0 for 3 polls, then 1
        log_q.delete();
        seg_base = seg_polls;
        seg_zero = 3;
        issue(2'b01, 32'h12345678, acc);
        wait_rsp(60, at);
        check_val("seg_latency", at - acc, 18);
        check_val("seg_events", log_q.size(), 5);
        if (log_q.size() == 5) begin
            for (int i = 0; i < 4; i++) begin
                check_val("seg_poll_addr", {24'h0, log_q[i].addr}, 32'h08);
                check_val("seg_poll_rd",   {31'h0, log_q[i].rd}, 32'h1);
            end
            for (int i = 0; i < 3; i++) begin
                check_val("seg_poll_spacing", log_q[i + 1].cyc - log_q[i].cyc, 5);
            end
            check_val("seg_xfer_after_poll", log_q[4].cyc - log_q[3].cyc, 1);
            check_val("seg_xfer_addr", {24'h0, log_q[4].addr}, 32'h0C);
            check_val("seg_xfer_we",   {31'h0, log_q[4].we}, 32'h1);
            check_val("seg_xfer_dout", log_q[4].dout, 32'h12345678);
        end
        accept_rsp();
        $display("SEG write rsp at cycle %0d", at);

        // SWX read: status already ready
        log_q.delete();
        swx_status = 1'b1;
        issue(2'b10, 32'h0, acc);
        wait_rsp(20, at);
        check_val("swx_latency", at - acc, 3);
        check_val("swx_events", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check_val("swx_poll_addr", {24'h0, log_q[0].addr}, 32'h10);
            check_val("swx_read_addr", {24'h0, log_q[1].addr}, 32'h14);
            check_val("swx_read_rd",   {31'h0, log_q[1].rd}, 32'h1);
        end
        check_val("swx_rsp_data", bus.rsp_data, 32'hDEADBEEF);
        check_val("swx_rsp_err",  {31'h0, bus.rsp_err}, 32'h0);
        accept_rsp();
        $display("SWX read rsp at cycle %0d", at);

        // CNT read with rsp_ready held low and a competing request
        log_q.delete();
        cnt_val = 32'h0BADF00D;
        issue(2'b11, 32'h0, acc);
        wait_rsp(20, at);
        check_val("cnt_latency", at - acc, 2);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("hold_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
            check_val("hold_rsp_data",  bus.rsp_data, 32'h0BADF00D);
            check_val("hold_req_ready", {31'h0, bus.req_ready}, 32'h0);
        end
        accept_rsp();
        repeat (5) @(negedge clk);
        check_val("hold_no_new_req", log_q.size(), 1);
        check_val("hold_idle_busy", {31'h0, busy}, 32'h0);
        $display("CNT read held response accepted at cycle %0d", cyc);

        // Status never ready
        log_q.delete();
        seg_base = seg_polls;
        seg_zero = 100000;
        issue(2'b01, 32'h55AA55AA, acc);
`ifdef IOM_TIMEOUT_EN
        wait_rsp(200, at);
        polls = 0;
        wes   = 0;
        foreach (log_q[i]) begin
            if (log_q[i].rd && log_q[i].addr == 8'h08) polls++;
            if (log_q[i].we) wes++;
        end
        check_val("to_poll_count", polls, 8);
        check_val("to_we_count", wes, 0);
        check_val("to_latency", at - acc, 37);
        check_val("to_rsp_err", {31'h0, bus.rsp_err}, 32'h1);
        check_val("to_rsp_data", bus.rsp_data, 32'h0);
        accept_rsp();
        $display("timeout rsp at cycle %0d after %0d polls", at, polls);
`else
        seen0 = rsp_seen;
        repeat (600) @(negedge clk);
        polls = 0;
        foreach (log_q[i]) begin
            if (log_q[i].rd && log_q[i].addr == 8'h08) polls++;
        end
        check_val("nto_polls_over_100", {31'h0, (polls > 100)}, 32'h1);
        check_val("nto_no_rsp", rsp_seen - seen0, 0);
        check_val("nto_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
        rstn = 1'b0;
        #1;
        check_val("nto_rst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        $display("no-timeout build polled %0d times, reset at cycle %0d", polls, cyc);
`endif

        // Reset during GAP of an SWX read
        swx_status = 1'b0;
        issue(2'b10, 32'h0, acc);
        @(negedge clk);
        check_val("gap_poll_rd", {31'h0, bus.io_rd}, 32'h1);
        @(negedge clk);
        check_val("gap_rd_low",  {31'h0, bus.io_rd}, 32'h0);
        check_val("gap_addr",    {24'h0, bus.io_addr}, 32'h10);
        rstn = 1'b0;
        #1;
        check_val("mid_rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        check_val("mid_rst_busy",      {31'h0, busy}, 32'h0);
        check_val("mid_rst_addr",      {24'h0, bus.io_addr}, 32'h0);
        check_val("mid_rst_strobes",   {30'h0, bus.io_we, bus.io_rd}, 32'h0);
        check_val("mid_rst_dout",      bus.io_dout, 32'h0);
        check_val("mid_rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        check_val("mid_rst_rsp_data",  bus.rsp_data, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        swx_status = 1'b1;
        log_q.delete();
        seen0 = rsp_seen;
        repeat (20) @(negedge clk);
        check_val("post_rst_no_rsp", rsp_seen - seen0, 0);
        check_val("post_rst_no_bus", log_q.size(), 0);
        $display("reset during GAP, released at cycle %0d", cyc);

        cnt_val = 32'h00001234;
        issue(2'b11, 32'h0, acc);
        wait_rsp(20, at);
        check_val("cnt2_latency", at - acc, 2);
        check_val("cnt2_rsp_data", bus.rsp_data, 32'h00001234);
        if (log_q.size() >= 1) begin
            check_val("cnt2_addr", {24'h0, log_q[0].addr}, 32'h18);
        end
        accept_rsp();
        $display("CNT read after reset rsp at cycle %0d data=0x00001234 expected", at);

        check_val("we_rd_never_together", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
